// File: rtl/apb_qch_ctrl.sv
// Q-channel power controller driving the APB isolator's qreqn from an idle counter and wake sources.
// Optional build macro QCH_DENY_CNT_EN adds an 8-bit saturating deny counter output deny_cnt_o.
module apb_qch_ctrl #(
    parameter int IDLE_W = 8
) (
    input  logic              pclk_i,
    input  logic              presetn_i,
    input  logic              en_i,
    input  logic              wake_req_i,
    input  logic [IDLE_W-1:0] idle_thresh_i,
    input  logic              qactive_i,
    input  logic              qacceptn_i,
    input  logic              qdeny_i,
    output logic              qreqn_o,
    output logic [2:0]        q_state_o,
    output logic              stopped_o
`ifdef QCH_DENY_CNT_EN
    ,
    output logic [7:0]        deny_cnt_o
`endif
);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_REQUEST  = 3'd1,
        ST_STOPPED  = 3'd2,
        ST_EXIT     = 3'd3,
        ST_DENIED   = 3'd4,
        ST_CONTINUE = 3'd5
    } q_state_t;

    q_state_t          state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              qreqn_q, qreqn_d;
    logic              idle, wake;

    assign idle = ~qactive_i & ~wake_req_i & en_i;
    assign wake = qactive_i | wake_req_i | ~en_i;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        case (state_q)
            ST_RUN: begin
                // Compare before increment, so the counter stops at the threshold and never wraps.
                if (!idle) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q >= idle_thresh_i) begin
                    state_d = ST_REQUEST;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            ST_REQUEST: begin
                // Wake is deliberately ignored until the isolator answers; accept beats deny.
                if (!qacceptn_i) begin
                    state_d = ST_STOPPED;
                end else if (qdeny_i) begin
                    state_d = ST_DENIED;
                end
            end
            ST_STOPPED: begin
                if (wake) begin
                    state_d = ST_EXIT;
                end
            end
            ST_EXIT: begin
                if (qacceptn_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_DENIED: begin
                state_d = ST_CONTINUE;
            end
            ST_CONTINUE: begin
                if (!qdeny_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_STOPPED;
            end
        endcase
    end

    // qreqn is registered from the next state so it has no combinational path from inputs.
    always_comb begin
        qreqn_d = (state_d == ST_RUN) || (state_d == ST_EXIT) || (state_d == ST_CONTINUE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            state_q    <= ST_STOPPED;
            idle_cnt_q <= '0;
            qreqn_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            qreqn_q    <= qreqn_d;
        end
    end

    assign qreqn_o   = qreqn_q;
    assign q_state_o = state_q;
    assign stopped_o = (state_q == ST_STOPPED);

`ifdef QCH_DENY_CNT_EN
    logic [7:0] deny_cnt_q;
    logic       deny_inc;

    assign deny_inc = (state_q == ST_REQUEST) && (state_d == ST_DENIED);

    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            deny_cnt_q <= 8'd0;
        end else if (deny_inc && (deny_cnt_q != 8'hff)) begin
            deny_cnt_q <= deny_cnt_q + 8'd1;
        end
    end

    assign deny_cnt_o = deny_cnt_q;
`endif

endmodule
